lsu_rmw: RTL and testbench

- Load/store unit directly upstream of the data memory in the multi-cycle RV32 core.
- Accepts one load/store request from the core datapath via a valid/ready handshake.
- Drives the data memory port (ctrl/addr/wdata, combinational read, synchronous write). Handles byte-lane alignment, sign/zero extension and misalignment detection.
- The memory writes only low lanes of a word, so SB/SH at any offset use a read-modify-write (RMW) sequence: word read, merge, word write.

---
 rtl/lsu_rmw_pkg.sv | 53 +++++
 rtl/lsu_rmw_if.sv | 30 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_rmw.sv | 122 ++++++++++++
 tb/tb_lsu_rmw.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_rmw_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes,
// data-memory op codes, FSM state type and the request legality check.
// Imported by the LSU top and its alignment helper.
package lsu_rmw_pkg;

  // RV32 load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Data memory op codes; MEM_NOP falls into the memory's default branch
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_SW  = 3'b110;
  localparam logic [2:0] MEM_NOP = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } lsu_state_t;

  // 1 when the request must be rejected: illegal funct3 or misaligned address
  function automatic logic lsu_req_error(input logic       we,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic err;
    err = 1'b1;
    if (we) begin
      case (f3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = lo[0];
        F3_SW:   err = (lo != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = lo[0];
        F3_LW:         err = (lo != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Bundle of core request/response and data-memory port signals.
// slave: the LSU side; master: core datapath plus memory side.
// Flow control is valid/ready on the request, a one-cycle pulse on the response.
interface lsu_rmw_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_misaligned_o;
  logic [2:0]  mem_ctrl_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misaligned_o,
           mem_ctrl_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misaligned_o,
           mem_ctrl_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_align.sv
// Lane extract + sign/zero extend for loads, lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; consumer samples the outputs when it needs them.
module lsu_align
  import lsu_rmw_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // pick the addressed byte and halfword out of the raw memory word
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // extend the selected lane; LW (and anything else) passes the word through
  always_comb begin
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load_data = {24'd0, w_byte};
      F3_LHU:  o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // replace only the target lanes; bytes outside them keep the read value
  always_comb begin
    o_merged = i_rdata;
    case (i_funct3)
      F3_SB: begin
        case (i_addr_lo)
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          2'd3:    o_merged[31:24] = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      F3_SH: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a low-lane-write data memory; SB/SH go read-merge-write.
// Latency accept->rsp: load 2, SW 2, SB/SH 3, rejected request 1.
// Backpressure: req_ready_o high only in IDLE; one request in flight at a time.
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter bit RESP_ON_STORE = 1'b1
)(
  input  logic      clk_i,
  input  logic      rst_ni,
  lsu_rmw_if.slave  bus
);

  lsu_state_t  r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_mis;
  logic [2:0]  r_mem_ctrl;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_err = lsu_req_error(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i[1:0]);

  lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr_lo),
    .i_rdata     (bus.mem_rdata_i),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // sequencing FSM; every memory and response output is registered here
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_mis   <= 1'b0;
      r_mem_ctrl  <= MEM_NOP;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      // pulse/strobe defaults; states below override for their one cycle
      r_rsp_valid <= 1'b0;
      r_mem_ctrl  <= MEM_NOP;
      r_mem_wdata <= 32'd0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_funct3  <= bus.req_funct3_i;
            r_addr_lo <= bus.req_addr_i[1:0];
            r_wdata   <= bus.req_wdata_i;
            if (w_err) begin
              // rejected: straight to response, memory never touched
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_mis   <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else begin
              r_mem_addr <= {bus.req_addr_i[31:2], 2'b00};
              if (!bus.req_we_i) begin
                r_state    <= LOAD;
                r_mem_ctrl <= MEM_LW;
              end else if (bus.req_funct3_i == F3_SW) begin
                r_state     <= WRITE;
                r_mem_ctrl  <= MEM_SW;
                r_mem_wdata <= bus.req_wdata_i;
              end else begin
                r_state    <= READ;
                r_mem_ctrl <= MEM_LW;
              end
            end
          end
        end
        LOAD: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_mis   <= 1'b0;
          r_rsp_rdata <= w_load_data;
        end
        READ: begin
          // merge against the word read this cycle, write it next cycle
          r_state     <= WRITE;
          r_mem_ctrl  <= MEM_SW;
          r_mem_wdata <= w_merged;
        end
        WRITE: begin
          if (RESP_ON_STORE) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_mis   <= 1'b0;
            r_rsp_rdata <= 32'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o      = (r_state == IDLE);
  assign bus.rsp_valid_o      = r_rsp_valid;
  assign bus.rsp_rdata_o      = r_rsp_rdata;
  assign bus.rsp_misaligned_o = r_rsp_mis;
  assign bus.mem_ctrl_o       = r_mem_ctrl;
  assign bus.mem_addr_o       = r_mem_addr;
  assign bus.mem_wdata_o      = r_mem_wdata;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: memory model, directed vectors, per-cycle compare against
// an abstract request-level model plus literal expectations per vector.
// Runs with RESP_ON_STORE=1.
module tb_lsu_rmw;
  import lsu_rmw_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_rmw_if bus ();

  lsu_rmw #(.RESP_ON_STORE(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // environment memory: combinational read, synchronous word write
  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  assign bus.mem_rdata_i = env_mem[bus.mem_addr_o[9:2]];
  always @(posedge clk) begin
    if (bus.mem_ctrl_o == MEM_SW) env_mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model state shared with the compare process
  int          ncyc = 0;
  int          acc_ncyc = -100;
  int          exp_rsp_cyc = -100;
  logic [31:0] exp_rd, exp_waddr, exp_wword;
  logic        exp_mis;
  int          exp_nlw, exp_nsw;
  int          n_lw = 0, n_sw = 0, n_rsp = 0;
  logic [31:0] last_rdata;
  logic        last_mis;

  // request-level model: size/offset arithmetic over a reference memory
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic mis,
                       output int lat, output int nlw, output int nsw, output logic [31:0] wword);
    int          size, off;
    bit          legal;
    logic [31:0] word, raw;
    off  = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis  = !legal || (f3[1:0] == 2'd3) || ((off % size) != 0);
    word = ref_mem[addr[9:2]];
    rd = 32'd0; nlw = 0; nsw = 0; wword = 32'd0;
    if (mis) begin
      lat = 1;
    end else if (!we) begin
      raw = word >> (8 * off);
      if (size == 1) begin
        rd = raw & 32'h0000_00FF;
        if (!f3[2] && raw[7]) rd = rd | 32'hFFFF_FF00;
      end else if (size == 2) begin
        rd = raw & 32'h0000_FFFF;
        if (!f3[2] && raw[15]) rd = rd | 32'hFFFF_0000;
      end else begin
        rd = word;
      end
      lat = 2; nlw = 1;
    end else begin
      wword = word;
      for (int i = 0; i < size; i++) wword[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[addr[9:2]] = wword;
      nsw = 1;
      nlw = (size < 4) ? 1 : 0;
      lat = (size < 4) ? 3 : 2;
    end
  endtask

  // per-cycle compare of every DUT output against the model
  always @(negedge clk) begin
    bit busy;
    ncyc++;
    busy = (ncyc > acc_ncyc) && (ncyc <= exp_rsp_cyc);
    chk("req_ready", {31'd0, bus.req_ready_o}, {31'd0, !busy});
    chk("rsp_valid", {31'd0, bus.rsp_valid_o}, {31'd0, ncyc == exp_rsp_cyc});
    if (ncyc == exp_rsp_cyc) begin
      chk("rsp_rdata", bus.rsp_rdata_o, exp_rd);
      chk("rsp_misaligned", {31'd0, bus.rsp_misaligned_o}, {31'd0, exp_mis});
      chk("mem_lw_cycles", n_lw, exp_nlw);
      chk("mem_sw_cycles", n_sw, exp_nsw);
    end
    if (bus.rsp_valid_o) begin
      last_rdata = bus.rsp_rdata_o;
      last_mis   = bus.rsp_misaligned_o;
      n_rsp++;
    end
    if (bus.mem_ctrl_o == MEM_LW) begin
      n_lw++;
      chk("lw_addr", bus.mem_addr_o, exp_waddr);
    end else if (bus.mem_ctrl_o == MEM_SW) begin
      n_sw++;
      chk("sw_addr", bus.mem_addr_o, exp_waddr);
      chk("sw_wdata", bus.mem_wdata_o, exp_wword);
    end else begin
      chk("mem_ctrl_idle", {29'd0, bus.mem_ctrl_o}, {29'd0, MEM_NOP});
      chk("mem_wdata_idle", bus.mem_wdata_o, 32'd0);
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        mis;
    logic        chkw;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [0:18];

  task automatic run_vec(input vec_t v, input int idx);
    int lat, rsp0;
    @(negedge clk); #1;
    model(v.we, v.f3, v.addr, v.wdata, exp_rd, exp_mis, lat, exp_nlw, exp_nsw, exp_wword);
    exp_waddr   = {v.addr[31:2], 2'b00};
    acc_ncyc    = ncyc;
    exp_rsp_cyc = ncyc + lat;
    n_lw = 0; n_sw = 0;
    rsp0 = n_rsp;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = v.we;
    bus.req_funct3_i = v.f3;
    bus.req_addr_i   = v.addr;
    bus.req_wdata_i  = v.wdata;
    @(negedge clk); #1;
    // garbage on the ignored inputs while busy
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = ~v.we;
    bus.req_funct3_i = 3'b111;
    bus.req_addr_i   = 32'h0000_0104;
    bus.req_wdata_i  = 32'hA5A5_A5A5;
    repeat (lat + 1) @(negedge clk);
    #1;
    chk($sformatf("v%0d_rsp_count", idx), n_rsp - rsp0, 32'd1);
    chk($sformatf("v%0d_rdata_lit", idx), last_rdata, v.rd);
    chk($sformatf("v%0d_mis_lit", idx), {31'd0, last_mis}, {31'd0, v.mis});
    if (v.chkw) chk($sformatf("v%0d_word_lit", idx), env_mem[v.addr[9:2]], v.word);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    env_mem[8'h40] = 32'h8899_AABB; ref_mem[8'h40] = 32'h8899_AABB;
    env_mem[8'h41] = 32'h1122_3344; ref_mem[8'h41] = 32'h1122_3344;

    //            we    f3      addr          wdata          rd literal     mis   chkw  word literal
    vecs[0]  = '{1'b0, F3_LB,  32'h0000_0103, 32'h0,         32'hFFFF_FF88, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, F3_LHU, 32'h0000_0102, 32'h0,         32'h0000_8899, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, F3_LH,  32'h0000_0100, 32'h0,         32'hFFFF_AABB, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, F3_LBU, 32'h0000_0101, 32'h0,         32'h0000_00AA, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, F3_LW,  32'h0000_0100, 32'h0,         32'h8899_AABB, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, F3_SB,  32'h0000_0101, 32'hFFFF_FF5A, 32'h0,         1'b0, 1'b1, 32'h8899_5ABB};
    vecs[6]  = '{1'b1, F3_SW,  32'h0000_0100, 32'h8899_AABB, 32'h0,         1'b0, 1'b1, 32'h8899_AABB};
    vecs[7]  = '{1'b1, F3_SH,  32'h0000_0102, 32'hABCD_1234, 32'h0,         1'b0, 1'b1, 32'h1234_AABB};
    vecs[8]  = '{1'b1, F3_SW,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, F3_LHU, 32'h0000_0102, 32'h0,         32'h0000_1234, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, F3_LB,  32'h0000_0100, 32'h0,         32'hFFFF_FFBB, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, F3_LW,  32'h0000_0102, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b1, F3_SH,  32'h0000_0101, 32'h0000_7777, 32'h0,         1'b1, 1'b1, 32'h1234_AABB};
    vecs[13] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 3'b011, 32'h0000_0100, 32'h5555_5555, 32'h0,         1'b1, 1'b1, 32'h1234_AABB};
    vecs[15] = '{1'b0, F3_LH,  32'h0000_0107, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b1, F3_SB,  32'h0000_0107, 32'h0000_007F, 32'h0,         1'b0, 1'b1, 32'h7FAD_BEEF};
    vecs[17] = '{1'b1, F3_SH,  32'h0000_0104, 32'h0000_5566, 32'h0,         1'b0, 1'b1, 32'h7FAD_5566};
    vecs[18] = '{1'b0, F3_LB,  32'h0000_0106, 32'h0,         32'hFFFF_FFAD, 1'b0, 1'b0, 32'h0};

    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
    chk("rst_mis", {31'd0, bus.rsp_misaligned_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_ctrl", {29'd0, bus.mem_ctrl_o}, 32'h7);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    // reset asserted while an SB is in its READ cycle
    @(negedge clk); #1;
    acc_ncyc    = ncyc;
    exp_rsp_cyc = ncyc + 3;
    exp_waddr   = 32'h0000_0100;
    n_lw = 0; n_sw = 0;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = F3_SB;
    bus.req_addr_i   = 32'h0000_0101;
    bus.req_wdata_i  = 32'h0000_0099;
    @(negedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("rmw_read_phase", {29'd0, bus.mem_ctrl_o}, 32'h2);
    rst_n       = 1'b0;
    acc_ncyc    = -100;
    exp_rsp_cyc = -100;
    #1;
    chk("midrst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("midrst_rdata", bus.rsp_rdata_o, 32'd0);
    chk("midrst_mem_ctrl", {29'd0, bus.mem_ctrl_o}, 32'h7);
    chk("midrst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("midrst_mem_wdata", bus.mem_wdata_o, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_no_sw", n_sw, 32'd0);
    chk("midrst_word_lit", env_mem[8'h40], 32'h1234_AABB);

    // normal operation resumes
    run_vec('{1'b1, F3_SB, 32'h0000_0100, 32'h0000_0077, 32'h0, 1'b0, 1'b1, 32'h1234_AA77}, 19);
    run_vec('{1'b0, F3_LW, 32'h0000_0100, 32'h0,         32'h1234_AA77, 1'b0, 1'b0, 32'h0}, 20);

    chk("final_word40", env_mem[8'h40], ref_mem[8'h40]);
    chk("final_word41", env_mem[8'h41], ref_mem[8'h41]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
